// File: rtl/core_seq_ctrl_if.sv
// Fetch (IFU) and load/store (LSU) handshake bundle used by the core_seq_ctrl sequencer.
// The master side issues requests; the slave side is the memory port.
interface core_seq_ctrl_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic lsu_req_valid;
  logic lsu_req_ready;
  logic lsu_rsp_valid;
  logic lsu_is_store;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    output lsu_req_valid,
    input  lsu_req_ready,
    input  lsu_rsp_valid,
    output lsu_is_store
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    output ifu_rsp_valid,
    input  lsu_req_valid,
    output lsu_req_ready,
    output lsu_rsp_valid,
    input  lsu_is_store
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory, writeback with IFU/LSU handshakes.
// Optional perf counters (cycle_cnt, instret_cnt) are built only when SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  core_seq_ctrl_if.master      mem,
  input  logic [6:0]           opcode,
  input  logic                 is_ebreak,
  input  logic                 dec_reg_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 halt,
  output logic                 err,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXEC       = 3'd3,
    ST_MEM_REQ    = 3'd4,
    ST_MEM_WAIT   = 3'd5,
    ST_WB         = 3'd6,
    ST_HALT       = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [7:0] TMO_LAST_C = 8'(MEM_TIMEOUT - 1);

  state_t     state_r, state_nxt_s;
  logic [7:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic       timeout_s;
  logic       halt_r, err_r;
  logic       ifu_req_valid_s, lsu_req_valid_s, lsu_is_store_s;
  logic       ir_we_s, pc_we_s, rf_we_s;

  // State, wait-timeout counter and sticky halt/error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH_REQ;
      tmo_cnt_r <= 8'd0;
      halt_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      if (state_nxt_s == ST_HALT) begin
        halt_r <= 1'b1;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Next-state and state-decoded strobes; a response on the limit cycle beats the timeout.
  always_comb begin
    state_nxt_s     = state_r;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    timeout_s       = 1'b0;
    ifu_req_valid_s = 1'b0;
    lsu_req_valid_s = 1'b0;
    lsu_is_store_s  = 1'b0;
    ir_we_s         = 1'b0;
    pc_we_s         = 1'b0;
    rf_we_s         = 1'b0;
    case (state_r)
      ST_FETCH_REQ: begin
        ifu_req_valid_s = 1'b1;
        if (mem.ifu_req_ready) begin
          state_nxt_s   = ST_FETCH_WAIT;
          tmo_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s   = ST_FETCH_REQ;
        end
      end
      ST_FETCH_WAIT: begin
        if (mem.ifu_rsp_valid) begin
          ir_we_s     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (tmo_cnt_r == TMO_LAST_C) begin
          state_nxt_s = ST_HALT;
          timeout_s   = 1'b1;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_DECODE: begin
        if (is_ebreak) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_nxt_s = ST_MEM_REQ;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        lsu_req_valid_s = 1'b1;
        lsu_is_store_s  = (opcode == OP_STORE);
        if (mem.lsu_req_ready) begin
          state_nxt_s   = ST_MEM_WAIT;
          tmo_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s   = ST_MEM_REQ;
        end
      end
      ST_MEM_WAIT: begin
        lsu_is_store_s = (opcode == OP_STORE);
        if (mem.lsu_rsp_valid) begin
          state_nxt_s = ST_WB;
        end else if (tmo_cnt_r == TMO_LAST_C) begin
          state_nxt_s = ST_HALT;
          timeout_s   = 1'b1;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_WB: begin
        pc_we_s     = 1'b1;
        rf_we_s     = dec_reg_we & (opcode != OP_STORE) & (opcode != OP_BRANCH);
        state_nxt_s = ST_FETCH_REQ;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // Reset forces every output low immediately, including an in-flight request.
  assign mem.ifu_req_valid = ifu_req_valid_s & ~rst;
  assign mem.lsu_req_valid = lsu_req_valid_s & ~rst;
  assign mem.lsu_is_store  = lsu_is_store_s  & ~rst;
  assign ir_we             = ir_we_s & ~rst;
  assign pc_we             = pc_we_s & ~rst;
  assign rf_we             = rf_we_s & ~rst;
  assign halt              = halt_r  & ~rst;
  assign err               = err_r   & ~rst;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_r, instret_cnt_r;

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r   <= '0;
      instret_cnt_r <= '0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      if (state_r == ST_WB) begin
        instret_cnt_r <= instret_cnt_r + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = rst ? '0 : cycle_cnt_r;
  assign instret_cnt = rst ? '0 : instret_cnt_r;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized self-checking bench for core_seq_ctrl: each instruction is modelled as a
// timeline of phases whose lengths follow from the handshake delays chosen for it.
module tb_core_seq_ctrl;
  localparam int T = 4;

  localparam logic [7:0] E_IFU  = 8'h80;
  localparam logic [7:0] E_LSU  = 8'h40;
  localparam logic [7:0] E_ST   = 8'h20;
  localparam logic [7:0] E_IR   = 8'h10;
  localparam logic [7:0] E_PC   = 8'h08;
  localparam logic [7:0] E_RF   = 8'h04;
  localparam logic [7:0] E_HALT = 8'h02;
  localparam logic [7:0] E_ERR  = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        is_ebreak = 1'b0;
  logic        dec_reg_we = 1'b0;
  logic        ir_we, pc_we, rf_we, halt, err;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [7:0]  obs;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc_no  = 0;
  int pc_seen = -1;
  logic [63:0] exp_cyc = 64'd0;
  logic [63:0] exp_ret = 64'd0;

  core_seq_ctrl_if mem_if ();

  core_seq_ctrl #(.MEM_TIMEOUT(T), .CNT_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if.master),
    .opcode     (opcode),
    .is_ebreak  (is_ebreak),
    .dec_reg_we (dec_reg_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .halt       (halt),
    .err        (err),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mem_if.ifu_req_valid, mem_if.lsu_req_valid, mem_if.lsu_is_store,
                ir_we, pc_we, rf_we, halt, err};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, sample at negedge, advance the counter model.
  task automatic cyc(input string tag, input logic rr, input logic rv,
                     input logic lr, input logic lv, input logic [7:0] exp);
    mem_if.ifu_req_ready = rr;
    mem_if.ifu_rsp_valid = rv;
    mem_if.lsu_req_ready = lr;
    mem_if.lsu_rsp_valid = lv;
    @(negedge clk);
    check_val(tag, {56'd0, obs}, {56'd0, exp});
`ifdef SEQ_PERF_CNT_EN
    check_val("cycle_cnt", cycle_cnt, rst ? 64'd0 : exp_cyc);
    check_val("instret_cnt", instret_cnt, rst ? 64'd0 : exp_ret);
`else
    check_val("cycle_cnt_tied", cycle_cnt, 64'd0);
    check_val("instret_cnt_tied", instret_cnt, 64'd0);
`endif
    if (pc_we) pc_seen = cyc_no;
    @(posedge clk);
    #1;
    cyc_no++;
    if (rst) begin
      exp_cyc = 64'd0;
      exp_ret = 64'd0;
    end else begin
      exp_cyc = exp_cyc + 64'd1;
      if (exp[3]) exp_ret = exp_ret + 64'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc("reset_outputs", rb(), rb(), rb(), rb(), 8'h00);
    rst = 1'b0;
  endtask

  task automatic expect_halt(input logic errf);
    for (int i = 0; i < 3; i++) begin
      cyc("halted", rb(), rb(), rb(), rb(), E_HALT | (errf ? E_ERR : 8'h00));
    end
    do_reset();
  endtask

  // a: fetch-ready delay, b: fetch-response delay (>=T times out),
  // c: LSU-ready delay, d: LSU-response delay (>=T times out).
  task automatic run_instr(input logic [6:0] opc, input logic ebk, input logic we,
                           input int a, input int b, input int c, input int d,
                           input logic abort_mw);
    int start;
    logic is_mem;
    logic [7:0] st;
    start   = cyc_no;
    pc_seen = -1;
    is_mem  = (opc == 7'h03) || (opc == 7'h23);
    st      = (opc == 7'h23) ? E_ST : 8'h00;
    opcode = 7'($urandom); is_ebreak = rb(); dec_reg_we = rb();
    for (int i = 0; i <= a; i++) cyc("fetch_req", i == a, rb(), rb(), rb(), E_IFU);
    if (b >= T) begin
      for (int i = 0; i < T; i++) cyc("fetch_wait", rb(), 1'b0, rb(), rb(), 8'h00);
      expect_halt(1'b1);
      return;
    end
    for (int i = 0; i <= b; i++) cyc("fetch_wait", rb(), i == b, rb(), rb(), (i == b) ? E_IR : 8'h00);
    opcode = opc; is_ebreak = ebk; dec_reg_we = we;
    cyc("decode", rb(), rb(), rb(), rb(), 8'h00);
    if (ebk) begin
      expect_halt(1'b0);
      return;
    end
    cyc("exec", rb(), rb(), rb(), rb(), 8'h00);
    if (is_mem) begin
      for (int i = 0; i <= c; i++) cyc("mem_req", rb(), rb(), i == c, rb(), E_LSU | st);
      if (d >= T) begin
        for (int i = 0; i < T; i++) cyc("mem_wait", rb(), rb(), rb(), 1'b0, st);
        expect_halt(1'b1);
        return;
      end
      for (int i = 0; i <= d; i++) begin
        if (abort_mw && i == 1) begin
          rst = 1'b1;
          cyc("reset_mid_mem", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
          rst = 1'b0;
          return;
        end
        cyc("mem_wait", rb(), rb(), rb(), i == d, st);
      end
    end
    cyc("writeback", rb(), rb(), rb(), rb(),
        E_PC | ((we && opc != 7'h23 && opc != 7'h63) ? E_RF : 8'h00));
    check_val("latency", 64'(pc_seen - start + 1),
              64'(5 + a + b + (is_mem ? 2 + c + d : 0)));
  endtask

  initial begin
    logic [6:0] ops [10];
    int sel, b, d;
    logic [6:0] opc;
    ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
    mem_if.ifu_req_ready = 1'b0; mem_if.ifu_rsp_valid = 1'b0;
    mem_if.lsu_req_ready = 1'b0; mem_if.lsu_rsp_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    run_instr(7'h13, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);  // addi, zero wait
    run_instr(7'h03, 1'b0, 1'b1, 0, 0, 3, 0, 1'b0);  // lw, ready low 3 cycles
    run_instr(7'h23, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);  // sw, rf_we suppressed
    run_instr(7'h63, 1'b0, 1'b1, 1, 2, 0, 0, 1'b0);  // branch, rf_we suppressed
    run_instr(7'h7f, 1'b0, 1'b0, 0, 3, 0, 0, 1'b0);  // illegal, ALU path, rsp on limit
    run_instr(7'h03, 1'b0, 1'b1, 0, 0, 0, 3, 1'b0);  // load response on limit cycle

    run_instr(7'h03, 1'b0, 1'b1, 0, 0, 0, 3, 1'b1);  // reset during MEM_WAIT
    cyc("late_lsu_rsp", 1'b0, 1'b0, 1'b0, 1'b1, E_IFU);
    for (int k = 0; k < 3; k++) run_instr(7'h13, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
`ifdef SEQ_PERF_CNT_EN
    check_val("instret_after_3", instret_cnt, 64'd3);
`else
    check_val("instret_after_3", instret_cnt, 64'd0);
`endif
    @(posedge clk); #1;
    do_reset();

    run_instr(7'h73, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);  // ebreak
    run_instr(7'h13, 1'b0, 1'b1, 0, T, 0, 0, 1'b0);  // fetch timeout
    run_instr(7'h23, 1'b0, 1'b1, 0, 0, 1, T, 1'b0);  // store response timeout

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      opc = (sel == 9) ? 7'($urandom) : ops[sel];
      b = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, T - 1);
      d = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(opc, $urandom_range(0, 15) == 0, rb(),
                $urandom_range(0, 2), b, $urandom_range(0, 2), d, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
